// File: rtl/taiga_types.sv
// ============================================================================
// Module      : taiga_types
// Description : Shared types for the RCA partial-reconfiguration request path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package taiga_types;

  localparam int C_GRID_SLOT_W = 5;
  localparam int C_OU_ID_W     = 4;

  typedef struct packed {
    logic [C_GRID_SLOT_W-1:0] grid_slot;
    logic [C_OU_ID_W-1:0]     ou_id;
  } pr_queue_inputs_t;

  typedef enum logic [1:0] {
    PRQ_IDLE  = 2'd0,
    PRQ_ISSUE = 2'd1,
    PRQ_BUSY  = 2'd2
  } pr_queue_state_t;

endpackage

`default_nettype wire

// File: rtl/pr_rr_arbiter.sv
// ============================================================================
// Module      : pr_rr_arbiter
// Description : Round-robin one-hot arbiter; pointer moves past the winner
//               only when the caller signals that the grant was taken.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pr_rr_arbiter #(
  parameter int NUM_CHANNELS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CHANNELS-1:0] i_req,
  input  logic                    i_advance,
  output logic [NUM_CHANNELS-1:0] o_grant
);

  localparam int C_PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [C_PTR_W-1:0] r_ptr;
  logic [C_PTR_W-1:0] w_ptr_next;
  logic [C_PTR_W-1:0] w_idx;
  logic               w_found;

  always_comb begin
    o_grant    = '0;
    w_ptr_next = r_ptr;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int off = 0; off < NUM_CHANNELS; off++) begin
      w_idx = C_PTR_W'((int'(r_ptr) + off) % NUM_CHANNELS);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        w_ptr_next     = C_PTR_W'((int'(r_ptr) + off + 1) % NUM_CHANNELS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pr_request_queue.sv
// ============================================================================
// Module      : pr_request_queue
// Description : Multi-source PR request queue with slot merging, feeding the
//               PR/ICAP controller one request at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pr_request_queue
  import taiga_types::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter int DEPTH        = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic             [NUM_CHANNELS-1:0] req_valid,
  input  pr_queue_inputs_t [NUM_CHANNELS-1:0] req_data,
  output logic             [NUM_CHANNELS-1:0] req_ready,
  input  logic                                flush,
  output logic                                pr_valid,
  output pr_queue_inputs_t                    pr_req,
  input  logic                                pr_ready,
  input  logic                                pr_done,
  output logic                                busy,
  output logic [$clog2(DEPTH+1)-1:0]          count,
  output logic                                full,
  output logic                                empty,
  output logic                                merged
);

  localparam int                 C_IDX_W = $clog2(DEPTH);
  localparam int                 C_CNT_W = $clog2(DEPTH+1);
  localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(DEPTH);

  pr_queue_inputs_t   r_mem [DEPTH];
  logic [DEPTH-1:0]   r_vld;
  logic [C_IDX_W-1:0] r_head;
  logic [C_IDX_W-1:0] r_tail;
  logic [C_CNT_W-1:0] r_count;
  logic               r_full;
  logic               r_empty;
  logic               r_merged;

  pr_queue_state_t    r_state;
  logic               r_pr_valid;
  pr_queue_inputs_t   r_pr_req;
  logic               r_busy;

  logic [NUM_CHANNELS-1:0] w_grant;
  pr_queue_inputs_t        w_cand;
  logic                    w_hit;
  logic [C_IDX_W-1:0]      w_hit_idx;
  logic                    w_pop;
  logic                    w_accept;
  logic                    w_push;
  logic                    w_merge;
  logic [C_CNT_W-1:0]      w_count_next;

  pr_rr_arbiter #(
    .NUM_CHANNELS (NUM_CHANNELS)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req_valid),
    .i_advance (w_accept),
    .o_grant   (w_grant)
  );

  always_comb begin
    w_cand = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (w_grant[ch]) w_cand = req_data[ch];
    end
  end

  assign w_pop = (r_state == PRQ_IDLE) && !r_empty && !flush;

  // The head entry leaving this cycle is already in flight, so it cannot absorb a merge.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (!w_hit && r_vld[e] && (r_mem[e].grid_slot == w_cand.grid_slot) &&
          !(w_pop && (r_head == C_IDX_W'(e)))) begin
        w_hit     = 1'b1;
        w_hit_idx = C_IDX_W'(e);
      end
    end
  end

  assign w_accept  = (|w_grant) && !flush && (w_hit || (r_count < C_DEPTH));
  assign w_push    = w_accept && !w_hit;
  assign w_merge   = w_accept && w_hit;
  assign req_ready = w_accept ? w_grant : '0;

  always_comb begin
    if (flush) w_count_next = '0;
    else       w_count_next = r_count + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < DEPTH; e++) r_mem[e] <= '0;
      r_vld    <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_merged <= 1'b0;
    end else begin
      r_merged <= w_merge;
      r_count  <= w_count_next;
      r_full   <= (w_count_next == C_DEPTH);
      r_empty  <= (w_count_next == '0);
      if (flush) begin
        r_vld  <= '0;
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_tail] <= w_cand;
          r_vld[r_tail] <= 1'b1;
          r_tail        <= r_tail + C_IDX_W'(1);
        end
        if (w_merge) r_mem[w_hit_idx].ou_id <= w_cand.ou_id;
        if (w_pop) begin
          r_vld[r_head] <= 1'b0;
          r_head        <= r_head + C_IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= PRQ_IDLE;
      r_pr_valid <= 1'b0;
      r_pr_req   <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        PRQ_IDLE: begin
          if (w_pop) begin
            r_pr_req   <= r_mem[r_head];
            r_pr_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= PRQ_ISSUE;
          end
        end
        PRQ_ISSUE: begin
          if (pr_ready) begin
            r_pr_valid <= 1'b0;
            r_state    <= PRQ_BUSY;
          end
        end
        PRQ_BUSY: begin
          if (pr_done) begin
            r_busy  <= 1'b0;
            r_state <= PRQ_IDLE;
          end
        end
        default: begin
          r_pr_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= PRQ_IDLE;
        end
      endcase
    end
  end

  assign pr_valid = r_pr_valid;
  assign pr_req   = r_pr_req;
  assign busy     = r_busy;
  assign count    = r_count;
  assign full     = r_full;
  assign empty    = r_empty;
  assign merged   = r_merged;

endmodule

`default_nettype wire
